// File: rtl/motion_pkg.sv
// Shared types and profile word layout for the motion sequencer.
package motion_pkg;

  localparam int PROFILE_WORDS = 5;
  localparam int IDX_N         = 0;
  localparam int IDX_NN        = 1;
  localparam int IDX_T0        = 2;
  localparam int IDX_TNA       = 3;
  localparam int IDX_DELTA     = 4;

  localparam int DEF_AXES = 4;
  localparam int DEF_PW   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [DEF_AXES-1:0]                      mask;
    logic [DEF_AXES*PROFILE_WORDS*DEF_PW-1:0] params;
  } move_cmd_t;

endpackage

// File: rtl/motion_cmd_fifo.sv
// Move command queue: synchronous FIFO with flush, full/empty flags and fill level.
module motion_cmd_fifo
  import motion_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter type item_t = move_cmd_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  item_t                  wr_data,
  output item_t                  rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  item_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/motion_sequencer.sv
// Multi-axis move scheduler: queues moves and holds axis start lines until every enabled axis finishes.
// state   | meaning
// IDLE    | nothing running, waiting for a queued move
// LOAD    | pop head, latch params and mask
// RUN     | start lines driven with mask, waiting for all masked finishes
// RELEASE | start low for one cycle so generators reset; move_done unless aborted
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int AXES  = 4,
  parameter int DEPTH = 8,
  parameter int PW    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [AXES-1:0]                 cmd_mask,
  input  logic [AXES*PROFILE_WORDS*PW-1:0] cmd_params,
  input  logic                            abort,
  output logic [AXES*PROFILE_WORDS*PW-1:0] axis_params,
  output logic [AXES-1:0]                 axis_start,
  input  logic [AXES-1:0]                 axis_finish,
  output logic                            busy,
  output logic                            move_done,
  output logic [$clog2(DEPTH):0]          fifo_level
);

  localparam int PRM_W = AXES * PROFILE_WORDS * PW;

  typedef struct packed {
    logic [AXES-1:0]  mask;
    logic [PRM_W-1:0] params;
  } cmd_t;

  cmd_t            wr_cmd;
  cmd_t            head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  seq_state_t      state_q;
  seq_state_t      state_d;
  logic [AXES-1:0] mask_q;
  logic [AXES-1:0] start_d;
  logic            done_d;

  assign wr_cmd    = {cmd_mask, cmd_params};
  assign cmd_ready = ~fifo_full;
  assign busy      = (state_q != IDLE) | ~fifo_empty;

  motion_cmd_fifo #(
    .DEPTH  (DEPTH),
    .item_t (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .pop     (pop),
    .flush   (abort),
    .wr_data (wr_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    start_d = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        pop     = 1'b1;
        start_d = head.mask;
        state_d = RUN;
      end
      RUN: begin
        if ((axis_finish & mask_q) == mask_q) begin
          state_d = RELEASE;
          done_d  = 1'b1;
        end else begin
          start_d = mask_q;
        end
      end
      RELEASE: state_d = fifo_empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
    // Abort outranks finish: the move still passes through RELEASE so generators reset.
    if (abort) begin
      pop     = 1'b0;
      start_d = '0;
      done_d  = 1'b0;
      state_d = (state_q == LOAD || state_q == RUN) ? RELEASE : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      axis_params <= '0;
      axis_start  <= '0;
      move_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      axis_start <= start_d;
      move_done  <= done_d;
      if (pop) begin
        mask_q      <= head.mask;
        axis_params <= head.params;
      end
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed self-checking bench for motion_sequencer with simple step-generator models.
module tb_motion_sequencer;
  import motion_pkg::*;

  localparam int AXES  = 4;
  localparam int DEPTH = 8;
  localparam int PW    = 32;
  localparam int PRM_W = AXES * PROFILE_WORDS * PW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AXES-1:0]  cmd_mask = '0;
  logic [PRM_W-1:0] cmd_params = '0;
  logic             abort = 1'b0;
  logic [PRM_W-1:0] axis_params;
  logic [AXES-1:0]  axis_start;
  logic [AXES-1:0]  axis_finish;
  logic             busy;
  logic             move_done;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  motion_sequencer #(.AXES(AXES), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mask    (cmd_mask),
    .cmd_params  (cmd_params),
    .abort       (abort),
    .axis_params (axis_params),
    .axis_start  (axis_start),
    .axis_finish (axis_finish),
    .busy        (busy),
    .move_done   (move_done),
    .fifo_level  (fifo_level)
  );

  // Generator model: counts cycles while start is high, raises finish after N counts.
  logic [AXES-1:0] gen_fin;
  logic [AXES-1:0] stall = '0;
  logic [AXES-1:0] spur = '0;
  int unsigned     gcnt [AXES];

  always @(posedge clk) begin
    for (int a = 0; a < AXES; a++) begin
      if (!axis_start[a]) begin
        gcnt[a]    <= 0;
        gen_fin[a] <= 1'b0;
      end else begin
        gcnt[a] <= gcnt[a] + 1;
        if (gcnt[a] + 1 >= axis_params[(a*PROFILE_WORDS+IDX_N)*PW +: PW]) gen_fin[a] <= 1'b1;
      end
    end
  end

  assign axis_finish = (gen_fin & ~stall) | spur;

  // Move monitor: records start mask and params at each move_done, and low gaps between moves.
  typedef struct {
    logic [AXES-1:0]  start_seen;
    logic [PRM_W-1:0] params;
  } obs_t;

  obs_t            obs_q[$];
  int              gaps[$];
  logic [AXES-1:0] start_acc = '0;
  logic [AXES-1:0] prev_start = '0;
  int              low_run = 0;
  bit              had_fall = 0;

  always @(negedge clk) begin
    if (axis_start != '0 && prev_start == '0 && had_fall) gaps.push_back(low_run);
    if (axis_start == '0) low_run++;
    else low_run = 0;
    if (prev_start != '0 && axis_start == '0) had_fall = 1;
    start_acc = start_acc | axis_start;
    if (move_done === 1'b1) begin
      obs_q.push_back('{start_acc, axis_params});
      start_acc = '0;
    end
    prev_start = axis_start;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [PRM_W-1:0] act, input logic [PRM_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PRM_W-1:0] make_params(input logic [31:0] n, input logic [31:0] t0);
    logic [PRM_W-1:0] p;
    p = '0;
    for (int a = 0; a < AXES; a++) begin
      p[(a*PROFILE_WORDS+IDX_N)*PW +: PW]     = n;
      p[(a*PROFILE_WORDS+IDX_NN)*PW +: PW]    = n >> 1;
      p[(a*PROFILE_WORDS+IDX_T0)*PW +: PW]    = t0 + 32'(a);
      p[(a*PROFILE_WORDS+IDX_TNA)*PW +: PW]   = t0 - 32'(a);
      p[(a*PROFILE_WORDS+IDX_DELTA)*PW +: PW] = 32'(a * 100 + 7);
    end
    return p;
  endfunction

  function automatic logic [31:0] word(input logic [PRM_W-1:0] p, input int a, input int w);
    return p[(a*PROFILE_WORDS+w)*PW +: PW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AXES-1:0] m, input logic [PRM_W-1:0] p);
    cmd_valid  = 1'b1;
    cmd_mask   = m;
    cmd_params = p;
    step();
    cmd_valid  = 1'b0;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    gaps.delete();
    had_fall  = 0;
    start_acc = '0;
  endtask

  task automatic wait_moves(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check(name, obs_q.size(), n);
  endtask

  typedef struct {
    logic [AXES-1:0] mask;
    logic [31:0]     n;
    logic [31:0]     t0;
    logic [AXES-1:0] exp_start;
    logic [31:0]     exp_n;
    logic [31:0]     exp_t3;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int hi;
    int overlap;
    logic [PRM_W-1:0] p;

    vecs[0] = '{4'b1111, 32'd3, 32'd1000, 4'b1111, 32'd3, 32'd1003};
    vecs[1] = '{4'b0011, 32'd4, 32'd2000, 4'b0011, 32'd4, 32'd2003};
    vecs[2] = '{4'b1000, 32'd2, 32'd3000, 4'b1000, 32'd2, 32'd3003};
    vecs[3] = '{4'b0000, 32'd7, 32'd4000, 4'b0000, 32'd7, 32'd4003};
    vecs[4] = '{4'b0101, 32'd5, 32'd5000, 4'b0101, 32'd5, 32'd5003};
    vecs[5] = '{4'b1010, 32'd3, 32'd6000, 4'b1010, 32'd3, 32'd6003};
    vecs[6] = '{4'b0001, 32'd6, 32'd7000, 4'b0001, 32'd6, 32'd7003};
    vecs[7] = '{4'b1100, 32'd2, 32'd8000, 4'b1100, 32'd2, 32'd8003};

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_axis_start", axis_start, 0);
    check("rst_axis_params", axis_params, 0);
    check("rst_move_done", move_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_fifo_level", fifo_level, 0);

    // Single move, mask 0011, N=10
    clear_mon();
    push(4'b0011, make_params(10, 500));
    step();
    check("t1_start_in_load", axis_start, 0);
    step();
    check("t1_start_rise", axis_start, 4'b0011);
    check("t1_param_n_ax0", word(axis_params, 0, IDX_N), 10);
    check("t1_param_t0_ax1", word(axis_params, 1, IDX_T0), 501);
    hi = 1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (move_done) break;
      if (axis_start == 4'b0011) hi++;
    end
    check("t1_move_done", move_done, 1);
    check("t1_start_cycles", hi, 11);
    check("t1_start_low_at_done", axis_start, 0);
    step();
    check("t1_done_one_shot", move_done, 0);
    check("t1_busy_fall", busy, 0);
    step();
    check("t1_done_count", obs_q.size(), 1);

    // Three moves back-to-back
    clear_mon();
    for (int i = 0; i < 3; i++) push(vecs[i].mask, make_params(vecs[i].n, vecs[i].t0));
    wait_moves(3, 200, "t2_moves_timeout");
    repeat (3) step();
    check("t2_done_count", obs_q.size(), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      check($sformatf("t2_start_%0d", i), obs_q[i].start_seen, vecs[i].exp_start);
      check($sformatf("t2_n_%0d", i), word(obs_q[i].params, 0, IDX_N), vecs[i].exp_n);
      check($sformatf("t2_t3_%0d", i), word(obs_q[i].params, 3, IDX_T0), vecs[i].exp_t3);
      check($sformatf("t2_params_%0d", i), obs_q[i].params, make_params(vecs[i].n, vecs[i].t0));
    end
    check("t2_gap_count", gaps.size(), 2);
    foreach (gaps[i]) check($sformatf("t2_gap_%0d", i), gaps[i], 2);

    // Fill the FIFO while axis 0 is stalled, then drain in order
    clear_mon();
    stall = 4'b0001;
    push(4'b0001, make_params(4, 9000));
    repeat (3) step();
    check("t3_stalled_start", axis_start, 4'b0001);
    for (int i = 0; i < 8; i++) push(vecs[i].mask, make_params(vecs[i].n, vecs[i].t0));
    check("t3_level_full", fifo_level, 8);
    check("t3_ready_low", cmd_ready, 0);
    push(4'b1111, make_params(1, 0));
    check("t3_level_after_extra", fifo_level, 8);
    stall = 4'b0000;
    wait_moves(9, 500, "t3_drain_timeout");
    repeat (3) step();
    check("t3_done_count", obs_q.size(), 9);
    if (obs_q.size() > 0) begin
      check("t3_first_start", obs_q[0].start_seen, 4'b0001);
      check("t3_first_n", word(obs_q[0].params, 0, IDX_N), 4);
    end
    for (int i = 0; i < 8 && i + 1 < obs_q.size(); i++) begin
      check($sformatf("t3_start_%0d", i), obs_q[i+1].start_seen, vecs[i].exp_start);
      check($sformatf("t3_n_%0d", i), word(obs_q[i+1].params, 0, IDX_N), vecs[i].exp_n);
      check($sformatf("t3_t3_%0d", i), word(obs_q[i+1].params, 3, IDX_T0), vecs[i].exp_t3);
    end
    check("t3_level_empty", fifo_level, 0);

    // Mask 0: completes with no start, move_done 3 cycles after accept
    clear_mon();
    push(4'b0000, make_params(3, 0));
    step();
    check("t4_done_k1", move_done, 0);
    step();
    check("t4_done_k2", move_done, 0);
    check("t4_start_k2", axis_start, 0);
    step();
    check("t4_done_k3", move_done, 1);
    step();
    check("t4_done_k4", move_done, 0);
    check("t4_busy_k4", busy, 0);

    // Unequal finish times plus spurious finish on an unmasked axis
    clear_mon();
    p = make_params(5, 100);
    p[(2*PROFILE_WORDS+IDX_N)*PW +: PW] = 32'd55;
    spur = 4'b0010;
    push(4'b0101, p);
    step();
    step();
    check("t5_start_rise", axis_start, 4'b0101);
    hi = 1;
    overlap = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (move_done) break;
      if (axis_start == 4'b0101) hi++;
      if (axis_finish[0] && axis_start == 4'b0101) overlap++;
    end
    check("t5_move_done", move_done, 1);
    check("t5_start_cycles", hi, 56);
    check("t5_ax0_early_cycles", overlap, 51);
    spur = 4'b0000;
    repeat (2) step();
    check("t5_done_count", obs_q.size(), 1);

    // Abort mid-RUN with 3 queued; a simultaneous push is dropped
    clear_mon();
    stall = 4'b0001;
    push(4'b0001, make_params(4, 0));
    for (int i = 0; i < 3; i++) push(vecs[i].mask, make_params(vecs[i].n, vecs[i].t0));
    check("t6_level_queued", fifo_level, 3);
    check("t6_start_running", axis_start, 4'b0001);
    abort      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_mask   = 4'b1111;
    cmd_params = make_params(2, 0);
    step();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("t6_start_cleared", axis_start, 0);
    check("t6_level_flushed", fifo_level, 0);
    check("t6_no_done", move_done, 0);
    check("t6_busy_release", busy, 1);
    step();
    check("t6_no_done_2", move_done, 0);
    check("t6_idle", busy, 0);
    repeat (5) step();
    check("t6_done_count", obs_q.size(), 0);
    stall = 4'b0000;

    // Async reset mid-RUN
    clear_mon();
    stall = 4'b0001;
    push(4'b0001, make_params(4, 0));
    push(vecs[0].mask, make_params(vecs[0].n, vecs[0].t0));
    push(vecs[1].mask, make_params(vecs[1].n, vecs[1].t0));
    check("t7_level_queued", fifo_level, 2);
    check("t7_start_running", axis_start, 4'b0001);
    #3 reset = 1'b1;
    #1;
    check("t7_start_async", axis_start, 0);
    check("t7_level_async", fifo_level, 0);
    check("t7_busy_async", busy, 0);
    check("t7_ready_async", cmd_ready, 1);
    check("t7_params_async", axis_params, 0);
    #1 reset = 1'b0;
    repeat (5) step();
    check("t7_done_count", obs_q.size(), 0);
    check("t7_busy_after", busy, 0);
    check("t7_start_after", axis_start, 0);
    stall = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
Multi-axis move scheduler that sits between the host command path and the per-axis jerk/acc/speed step-pulse generators. It buffers move commands in a FIFO and loads each move's five-word profile into every enabled axis. It holds the axes' start lines high until every enabled axis reports finish, then releases them and advances to the next move. This keeps all axes of one move synchronised: a new move never starts until the previous one has finished on every enabled axis.

Parameters:
AXES, 4, number of step-pulse generators driven
DEPTH, 8, command FIFO depth in entries (power of two, ≥2)
PW, 32, width of each profile word

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command word offered
cmd_ready  out  1  FIFO can accept; high when fifo_level < DEPTH
cmd_mask  in  AXES  per-axis enable for this move
cmd_params  in  AXES×5×PW  per-axis profile: [0] N steps, [1] nn accel steps, [2] t0 max delay, [3] tna min delay, [4] delta
abort  in  1  flush queue and stop the current move
axis_params  out  AXES×5×PW  registered profile presented to the generators
axis_start  out  AXES  registered start line for each generator
axis_finish  in  AXES  finish line from each generator
busy  out  1  state ≠ IDLE or FIFO non-empty
move_done  out  1  one-cycle pulse per completed (non-aborted) move
fifo_level  out  $clog2(DEPTH)+1  entries queued

Behaviour:
- Reset (async, mid-operation included):
  - state=IDLE; FIFO emptied; fifo_level=0.
  - axis_start=0; axis_params=0; move_done=0; busy=0; cmd_ready=1.
- Push: a command is accepted on a clk edge where cmd_valid & cmd_ready. Writes while full are impossible because cmd_ready=0.
- FSM states: IDLE, LOAD, RUN, RELEASE.
  - IDLE: FIFO non-empty → LOAD.
  - LOAD: pop the head; register its params into axis_params and its mask into an internal mask register → RUN.
  - RUN: axis_start = mask. If (axis_finish & mask) == mask → RELEASE with axis_start=0. Bits of axis_finish outside the mask are ignored. Mask=0 completes on the first RUN cycle.
  - RELEASE: axis_start=0 for exactly one cycle, so the generators see start low and reset their counters. move_done=1 for this cycle. Next state: LOAD if FIFO non-empty, else IDLE.
- Latency: command accepted at edge k → LOAD at k+1 → axis_start high from k+2. Back-to-back moves have a 2-cycle gap in axis_start (RELEASE, LOAD).
- axis_params stay stable from LOAD through RELEASE. The generators read params continuously, so they must not change while start is high.
- Pop and push in the same cycle are both honoured; fifo_level is unchanged.
- Abort (sampled on clk edge, any state):
  - FIFO is flushed (a push in the same cycle is dropped).
  - If in LOAD or RUN → RELEASE, with move_done suppressed.
  - If in RELEASE → IDLE.
  - axis_start=0 from the next cycle.
  - abort has priority over the finish condition.
- Widths: fifo_level counts 0..DEPTH inclusive. FIFO pointers wrap modulo DEPTH.

Decomposition:
- Package motion_pkg:
  - PROFILE_WORDS=5 and indices IDX_N=0, IDX_NN=1, IDX_T0=2, IDX_TNA=3, IDX_DELTA=4.
  - seq_state_t enum.
  - move_cmd_t packed struct {mask, params}.
- Sub-module motion_cmd_fifo: synchronous FIFO of move_cmd_t with async active-high reset, flush input, full/empty flags and level output.

Test Plan:
- Single move, mask=4'b0011, N=10. Generator models raise finish after 10 steps → axis_start[1:0] high 2 cycles after accept; drops the cycle after both finish are high; move_done pulses once; busy falls the cycle after.
- Three moves queued back-to-back → exactly three move_done pulses. axis_start is low for exactly 2 cycles between moves, and axis_params match each command in order.
- Fill 8 commands while axis 0 is stalled (finish held low) → cmd_ready=0 at fifo_level=8; further cmd_valid is ignored. Releasing finish drains the FIFO in order.
- Mask=4'b0000 command → axis_start stays 0; move_done pulses 3 cycles after accept.
- Unequal finish times, mask=4'b0101, axis 0 finishing 50 cycles before axis 2 → axis_start stays high on both until axis 2 finishes. Spurious finish on axis 1 is ignored.
- Abort mid-RUN with 3 queued, and separately async reset mid-RUN → axis_start=0 next cycle, fifo_level=0, no move_done, state returns to IDLE.
